// File: rtl/serial_uart_bridge.sv
// ---------------------------------------------------------------------------
// serial_uart_bridge
//  Connects the processor's serial port to an 8N1 UART line. Bytes written by
//  the CPU are queued in a small TX FIFO and shifted out LSB first. Incoming
//  frames are deserialised into a one-byte holding register for the CPU.
//
//  Parameters
//   CLKS_PER_BIT   clock cycles per UART bit (>= 4)
//   TX_FIFO_DEPTH  TX FIFO entries (power of 2, >= 2)
//
//  Ports
//   clock, reset       system clock; asynchronous active-high reset
//   uart_rx_in         serial line in (asynchronous, idles high)
//   uart_tx_out        serial line out (registered, idles high)
//   tx_data_in/wren_in byte push into the TX FIFO
//   tx_ready_out       TX FIFO not full
//   rx_data_out        last received byte
//   rx_valid_out       rx_data_out holds an unread byte
//   rx_rden_in         CPU consumed rx_data_out
//   rx_overrun_out     sticky: a received byte was dropped
//   rx_frame_err_out   one-cycle pulse: stop bit sampled low
//
//  Build option
//   SERIAL_LOOPBACK_EN  when defined the receiver listens to the internal
//                       transmit line; uart_tx_out is held high and
//                       uart_rx_in is ignored.
// ---------------------------------------------------------------------------
module serial_uart_bridge #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int TX_FIFO_DEPTH = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   input  logic [7:0] tx_data_in,
   input  logic       tx_wren_in,
   output logic       tx_ready_out,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   input  logic       rx_rden_in,
   output logic       rx_overrun_out,
   output logic       rx_frame_err_out
);

   localparam int AW = $clog2(TX_FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(TX_FIFO_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- TX FIFO ----------------
   logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          push, pop;
   tx_state_t     tx_state_reg;

   // Full check uses the registered count, so a same-cycle pop never frees room.
   assign tx_ready_out = (count_reg != FULL_CNT);
   assign push         = tx_wren_in && tx_ready_out;
   // Pop decision uses the registered count: a push into an empty FIFO waits a cycle.
   assign pop          = (tx_state_reg == TX_IDLE) && (count_reg != '0);

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_reg] <= tx_data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW + 1)'(1);
            2'b01:   count_reg <= count_reg - (AW + 1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ---------------- TX shifter ----------------
   logic [CW-1:0] tx_cnt_reg;
   logic [2:0]    tx_bit_reg;
   logic [7:0]    tx_shift_reg;
   logic          tx_line_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_line_reg  <= 1'b1;
      end else begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (pop) begin
                  tx_shift_reg <= fifo_mem[rd_ptr_reg];
                  tx_line_reg  <= 1'b0;
                  tx_cnt_reg   <= '0;
                  tx_state_reg <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg   <= '0;
                  tx_bit_reg   <= '0;
                  tx_line_reg  <= tx_shift_reg[0];
                  tx_state_reg <= TX_DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + CW'(1);
               end
            end
            TX_DATA: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg <= '0;
                  if (tx_bit_reg == 3'd7) begin
                     tx_line_reg  <= 1'b1;
                     tx_state_reg <= TX_STOP;
                  end else begin
                     // Line already shows bit 0 of the shifter; present the next one.
                     tx_line_reg  <= tx_shift_reg[1];
                     tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                     tx_bit_reg   <= tx_bit_reg + 3'd1;
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + CW'(1);
               end
            end
            default: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg   <= '0;
                  tx_state_reg <= TX_IDLE;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + CW'(1);
               end
            end
         endcase
      end
   end

   // ---------------- Line routing ----------------
   logic rx_line;
`ifdef SERIAL_LOOPBACK_EN
   logic unused_rx_in;
   assign unused_rx_in = uart_rx_in;
   assign uart_tx_out  = 1'b1;
   assign rx_line      = tx_line_reg;
`else
   assign uart_tx_out  = tx_line_reg;
   assign rx_line      = uart_rx_in;
`endif

   // ---------------- RX ----------------
   rx_state_t     rx_state_reg;
   logic          rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
   logic [CW-1:0] rx_cnt_reg;
   logic [2:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg, rx_data_reg;
   logic          rx_valid_reg, rx_overrun_reg, rx_ferr_reg;
   logic          rx_done;

   assign rx_done = (rx_state_reg == RX_STOP) && (rx_cnt_reg == BIT_LAST) && rx_sync2_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state_reg   <= RX_IDLE;
         rx_sync1_reg   <= 1'b1;
         rx_sync2_reg   <= 1'b1;
         rx_prev_reg    <= 1'b1;
         rx_cnt_reg     <= '0;
         rx_bit_reg     <= '0;
         rx_shift_reg   <= '0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         rx_overrun_reg <= 1'b0;
         rx_ferr_reg    <= 1'b0;
      end else begin
         rx_sync1_reg <= rx_line;
         rx_sync2_reg <= rx_sync1_reg;
         rx_prev_reg  <= rx_sync2_reg;
         rx_ferr_reg  <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               // Start only on a high-to-low transition, so a line stuck low
               // after a framing error is not taken as a new start bit.
               if (!rx_sync2_reg && rx_prev_reg) begin
                  rx_cnt_reg   <= '0;
                  rx_state_reg <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt_reg == HALF_LAST) begin
                  rx_cnt_reg   <= '0;
                  rx_bit_reg   <= '0;
                  rx_state_reg <= rx_sync2_reg ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + CW'(1);
               end
            end
            RX_DATA: begin
               if (rx_cnt_reg == BIT_LAST) begin
                  rx_cnt_reg   <= '0;
                  rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                  if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                  else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + CW'(1);
               end
            end
            default: begin
               if (rx_cnt_reg == BIT_LAST) begin
                  rx_cnt_reg   <= '0;
                  rx_state_reg <= RX_IDLE;
                  if (!rx_sync2_reg) rx_ferr_reg <= 1'b1;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + CW'(1);
               end
            end
         endcase

         // Holding register: a read and a completed byte in the same cycle
         // behave as "consume old, load new".
         if (rx_rden_in) begin
            rx_valid_reg   <= 1'b0;
            rx_overrun_reg <= 1'b0;
         end
         if (rx_done) begin
            if (rx_valid_reg && !rx_rden_in) begin
               rx_overrun_reg <= 1'b1;
            end else begin
               rx_data_reg  <= rx_shift_reg;
               rx_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign rx_data_out      = rx_data_reg;
   assign rx_valid_out     = rx_valid_reg;
   assign rx_overrun_out   = rx_overrun_reg;
   assign rx_frame_err_out = rx_ferr_reg;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_serial_uart_bridge
//  Self-checking bench for serial_uart_bridge with CLKS_PER_BIT=4 and
//  TX_FIFO_DEPTH=4. Inputs change on the falling edge, outputs are sampled on
//  the falling edge. A background decoder turns uart_tx_out back into bytes;
//  receive checks use a byte-level model of the holding register.
//  Build option SERIAL_LOOPBACK_EN selects the loopback-only scenario.
// ---------------------------------------------------------------------------
module tb_serial_uart_bridge;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       uart_rx_in = 1'b1;
   logic       uart_tx_out;
   logic [7:0] tx_data_in = 8'h00;
   logic       tx_wren_in = 1'b0;
   logic       tx_ready_out;
   logic [7:0] rx_data_out;
   logic       rx_valid_out;
   logic       rx_rden_in = 1'b0;
   logic       rx_overrun_out;
   logic       rx_frame_err_out;

   serial_uart_bridge #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(DEPTH)) dut (
      .clock            (clock),
      .reset            (reset),
      .uart_rx_in       (uart_rx_in),
      .uart_tx_out      (uart_tx_out),
      .tx_data_in       (tx_data_in),
      .tx_wren_in       (tx_wren_in),
      .tx_ready_out     (tx_ready_out),
      .rx_data_out      (rx_data_out),
      .rx_valid_out     (rx_valid_out),
      .rx_rden_in       (rx_rden_in),
      .rx_overrun_out   (rx_overrun_out),
      .rx_frame_err_out (rx_frame_err_out)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Count frame-error pulse cycles.
   int ferr_seen = 0;
   always @(negedge clock) if (rx_frame_err_out === 1'b1) ferr_seen++;

   // Line decoder: samples each bit near its middle.
   logic [7:0] dec_q[$];
   initial begin : decoder
      logic [7:0] b;
      b = 8'h00;
      forever begin
         @(negedge clock);
         if (!reset && uart_tx_out === 1'b0) begin
            repeat (2) @(negedge clock);
            if (uart_tx_out === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge clock);
                  b[i] = uart_tx_out;
               end
               repeat (CPB) @(negedge clock);
               dec_q.push_back(b);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic push_byte(input logic [7:0] b);
      tx_data_in = b;
      tx_wren_in = 1'b1;
      tick(1);
      tx_wren_in = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx_in = b[i];
         tick(CPB);
      end
      uart_rx_in = stop;
      tick(CPB);
      uart_rx_in = 1'b1;
      tick(8);
   endtask

   task automatic pulse_read();
      rx_rden_in = 1'b1;
      tick(1);
      rx_rden_in = 1'b0;
      tick(1);
   endtask

   int dec_rd = 0;

   task automatic wait_dec(input int n, input int budget);
      int t;
      t = 0;
      while (dec_q.size() < n && t < budget) begin
         tick(1);
         t++;
      end
      if (dec_q.size() < n) chk("tx_decode_timeout", dec_q.size(), n);
   endtask

   task automatic expect_dec(input string name, input logic [7:0] exp);
      if (dec_rd < dec_q.size()) chk(name, dec_q[dec_rd], exp);
      else                       chk({name, "_missing"}, 32'd0, 32'd1);
      dec_rd++;
   endtask

   typedef struct {
      logic       rd;
      logic [7:0] data;
      logic       stop;
      logic       ev;
      logic [7:0] ed;
      logic       eo;
      int         ef;
   } rx_vec_t;

   rx_vec_t tbl[8];

   initial begin : main
      logic       wav[42];
      logic       exp_wav[42];
      logic [7:0] exp_q[$];
      logic [7:0] a5;
      logic [7:0] b;
      logic       st, rd;
      logic       m_valid, m_ov;
      logic [7:0] m_data;
      int         first_low, mism, f0, lows, t;

      // read before frame, byte, stop bit, expected valid/data/overrun/frame-err pulses
      tbl[0] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 0};
      tbl[1] = '{1'b0, 8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 0};
      tbl[2] = '{1'b1, 8'h55, 1'b0, 1'b0, 8'h11, 1'b0, 1};
      tbl[3] = '{1'b0, 8'hA7, 1'b1, 1'b1, 8'hA7, 1'b0, 0};
      tbl[4] = '{1'b0, 8'h80, 1'b0, 1'b1, 8'hA7, 1'b0, 1};
      tbl[5] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 0};
      tbl[6] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hC3, 1'b1, 0};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, 0};

      tick(3);
      reset = 1'b0;
      tick(2);
      chk("reset_tx_line", uart_tx_out, 1);
      chk("reset_tx_ready", tx_ready_out, 1);
      chk("reset_rx_data", rx_data_out, 8'h00);
      chk("reset_rx_valid", rx_valid_out, 0);
      chk("reset_rx_overrun", rx_overrun_out, 0);
      chk("reset_rx_frame_err", rx_frame_err_out, 0);

`ifdef SERIAL_LOOPBACK_EN
      lows = 0;
      push_byte(8'h5A);
      for (int i = 0; i < 80; i++) begin
         if (uart_tx_out !== 1'b1) lows++;
         tick(1);
      end
      chk("lb_tx_line_held_high", lows, 0);
      chk("lb_rx_valid", rx_valid_out, 1);
      chk("lb_rx_data", rx_data_out, 8'h5A);
`else
      // ---- single byte waveform ----
      a5 = 8'hA5;
      exp_wav[0] = 1'b1;
      for (int i = 1; i <= 4; i++) exp_wav[i] = 1'b0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < CPB; j++) exp_wav[5 + k*CPB + j] = a5[k];
      for (int i = 37; i < 42; i++) exp_wav[i] = 1'b1;
      tx_data_in = a5;
      tx_wren_in = 1'b1;
      for (int i = 0; i < 42; i++) begin
         tick(1);
         tx_wren_in = 1'b0;
         wav[i] = uart_tx_out;
      end
      first_low = -1;
      mism = 0;
      for (int i = 0; i < 42; i++) begin
         if (first_low < 0 && wav[i] === 1'b0) first_low = i;
         if (wav[i] !== exp_wav[i]) mism++;
      end
      chk("t1_start_latency", first_low, 1);
      chk("t1_waveform_mismatches", mism, 0);
      wait_dec(dec_rd + 1, 100);
      expect_dec("t1_decoded", 8'hA5);

      // ---- fill past full ----
      tick(10);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t2_ready_before_push%0d", i + 1), tx_ready_out, (i < 5) ? 1 : 0);
         tx_data_in = 8'(i + 1);
         tx_wren_in = 1'b1;
         tick(1);
      end
      tx_wren_in = 1'b0;
      wait_dec(dec_rd + 5, 5 * 50);
      for (int i = 0; i < 5; i++) expect_dec($sformatf("t2_byte%0d", i + 1), 8'(i + 1));
      tick(60);
      chk("t2_no_extra_byte", dec_q.size(), dec_rd);

      // ---- randomized transmit ----
      for (int n = 0; n < 20; n++) begin
         tick($urandom_range(0, 30));
         t = 0;
         while (tx_ready_out !== 1'b1 && t < 200) begin
            tick(1);
            t++;
         end
         b = 8'($urandom);
         push_byte(b);
         exp_q.push_back(b);
      end
      wait_dec(dec_rd + exp_q.size(), 20 * 50 + 100);
      foreach (exp_q[i]) expect_dec($sformatf("rand_tx%0d", i), exp_q[i]);

      // ---- receive: glitch, then single frame and read ----
      f0 = ferr_seen;
      uart_rx_in = 1'b0;
      tick(1);
      uart_rx_in = 1'b1;
      tick(20);
      chk("glitch_no_valid", rx_valid_out, 0);
      chk("glitch_no_frame_err", ferr_seen - f0, 0);

      send_frame(8'h3C, 1'b1);
      chk("t3_valid", rx_valid_out, 1);
      chk("t3_data", rx_data_out, 8'h3C);
      rx_rden_in = 1'b1;
      tick(1);
      rx_rden_in = 1'b0;
      chk("t3_valid_after_read", rx_valid_out, 0);
      chk("t3_data_kept", rx_data_out, 8'h3C);
      tick(2);

      // ---- receive table ----
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].rd) pulse_read();
         f0 = ferr_seen;
         send_frame(tbl[i].data, tbl[i].stop);
         chk($sformatf("row%0d_valid", i), rx_valid_out, tbl[i].ev);
         chk($sformatf("row%0d_data", i), rx_data_out, tbl[i].ed);
         chk($sformatf("row%0d_overrun", i), rx_overrun_out, tbl[i].eo);
         chk($sformatf("row%0d_frame_err_cycles", i), ferr_seen - f0, tbl[i].ef);
      end

      // ---- randomized receive against byte-level model ----
      pulse_read();
      m_valid = 1'b0;
      m_ov    = 1'b0;
      m_data  = rx_data_out;   // data is unchanged by a read; model tracks it from here
      m_data  = 8'hC3;
      for (int n = 0; n < 15; n++) begin
         rd = 1'($urandom_range(0, 1));
         if (rd) begin
            pulse_read();
            m_valid = 1'b0;
            m_ov    = 1'b0;
         end
         b  = 8'($urandom);
         st = ($urandom_range(0, 3) != 0);
         f0 = ferr_seen;
         send_frame(b, st);
         if (st) begin
            if (!m_valid) begin
               m_data  = b;
               m_valid = 1'b1;
            end else begin
               m_ov = 1'b1;
            end
         end
         chk($sformatf("rand_rx%0d_valid", n), rx_valid_out, m_valid);
         chk($sformatf("rand_rx%0d_data", n), rx_data_out, m_data);
         chk($sformatf("rand_rx%0d_overrun", n), rx_overrun_out, m_ov);
         chk($sformatf("rand_rx%0d_frame_err", n), ferr_seen - f0, st ? 0 : 1);
      end

      // ---- reset in the middle of a transmit ----
      tick(60);
      for (int i = 0; i < 5; i++) push_byte(8'h00);
      tick(2);
      chk("pre_reset_line_low", uart_tx_out, 0);
      chk("pre_reset_fifo_full", tx_ready_out, 0);
      reset = 1'b1;
      #1;
      chk("midtx_reset_line_high", uart_tx_out, 1);
      chk("midtx_reset_ready", tx_ready_out, 1);
      chk("midtx_reset_rx_valid", rx_valid_out, 0);
      tick(2);
      reset = 1'b0;
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (uart_tx_out !== 1'b1) lows++;
      end
      chk("post_reset_line_idle", lows, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
